// File: rtl/ext_irq_ctrl_if.sv
// Processor-facing interrupt bundle: source levels and enable writes in, request/id/pending out.
// The controller binds to the slave modport; whoever drives the sources binds to master.
interface ext_irq_ctrl_if #(
    parameter int NSRC = 8,
    parameter int IDW  = $clog2(NSRC)
);
    logic [NSRC-1:0] irq_src;
    logic            en_we;
    logic [NSRC-1:0] en_wdata;
    logic            ExtIAck;
    logic            ExtIRQ;
    logic [IDW-1:0]  irq_id;
    logic [NSRC-1:0] pending;

    modport master (
        output irq_src, en_we, en_wdata, ExtIAck,
        input  ExtIRQ, irq_id, pending
    );

    modport slave (
        input  irq_src, en_we, en_wdata, ExtIAck,
        output ExtIRQ, irq_id, pending
    );
endinterface

// File: rtl/ext_irq_ctrl.sv
// Edge-triggered interrupt controller: lowest enabled pending source is presented until ExtIAck. Source-to-ExtIRQ
// latency 2 edges (4 with EXT_IRQ_SYNC_EN). No backpressure on sources; a request is held until acknowledged.
module ext_irq_ctrl #(
    parameter int              NSRC     = 8,
    parameter int              IDW      = $clog2(NSRC),
    parameter logic [NSRC-1:0] EN_RESET = '1
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    ext_irq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        ACKED  = 2'd2
    } state_t;

    state_t          state_q;
    logic            ext_irq_q;
    logic [IDW-1:0]  irq_id_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] en_q;
    logic [NSRC-1:0] irq_prev_q;
    logic [NSRC-1:0] src_s;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] sel;
    logic [IDW-1:0]  sel_id;
    logic            sel_any;

`ifdef EXT_IRQ_SYNC_EN
    logic [NSRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = bus.irq_src;
`endif

    assign rise = src_s & ~irq_prev_q;
    assign sel  = pending_q & en_q;

    always_comb begin
        clr = '0;
        if (state_q == ASSERT && bus.ExtIAck) begin
            clr[irq_id_q] = 1'b1;
        end
    end

    // A fresh edge on the source being acknowledged must survive the clear.
    assign pending_d = (pending_q & ~clr) | rise;

    // Scan from the top so the lowest set index is the one left standing.
    always_comb begin
        sel_id  = '0;
        sel_any = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (sel[i]) begin
                sel_id  = IDW'(i);
                sel_any = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ext_irq_q  <= 1'b0;
            irq_id_q   <= '0;
            pending_q  <= '0;
            irq_prev_q <= '0;
            en_q       <= EN_RESET;
        end else begin
            irq_prev_q <= src_s;
            pending_q  <= pending_d;
            if (bus.en_we) begin
                en_q <= bus.en_wdata;
            end
            case (state_q)
                IDLE: begin
                    if (sel_any) begin
                        state_q   <= ASSERT;
                        ext_irq_q <= 1'b1;
                        irq_id_q  <= sel_id;
                    end
                end
                ASSERT: begin
                    if (bus.ExtIAck) begin
                        state_q   <= ACKED;
                        ext_irq_q <= 1'b0;
                    end
                end
                ACKED: begin
                    if (!bus.ExtIAck) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ext_irq_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ExtIRQ  = ext_irq_q;
    assign bus.irq_id  = irq_id_q;
    assign bus.pending = pending_q;
endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Randomized and directed bench for ext_irq_ctrl against a cycle-level reference of the interrupt rules.
module tb_ext_irq_ctrl;
    localparam int N = 8;
`ifdef EXT_IRQ_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic CLOCK_50;
    logic reset;

    ext_irq_ctrl_if #(.NSRC(N)) bus ();

    ext_irq_ctrl #(.NSRC(N)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_vec = 0;
    int n_bad = 0;

    // Reference: presenting = request on the wire, waiting_release = acknowledged but ack still high.
    logic [N-1:0] m_pend;
    logic [N-1:0] m_en;
    logic [N-1:0] m_prev;
    logic [N-1:0] m_hist[$];
    bit           presenting;
    bit           waiting_release;
    int           m_id;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_en = '1;
        m_prev = '0;
        m_hist.delete();
        for (int i = 0; i < SD; i++) m_hist.push_back('0);
        presenting = 0;
        waiting_release = 0;
        m_id = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] seen, edges, old_pend, old_en;
        int low;
        m_hist.push_back(bus.irq_src);
        seen = m_hist.pop_front();
        edges = seen & ~m_prev;
        m_prev = seen;
        old_pend = m_pend;
        old_en = m_en;
        m_pend = old_pend | edges;
        if (presenting) begin
            if (bus.ExtIAck) begin
                if (!edges[m_id]) m_pend[m_id] = 1'b0;
                presenting = 0;
                waiting_release = 1;
            end
        end else if (waiting_release) begin
            if (!bus.ExtIAck) waiting_release = 0;
        end else begin
            low = -1;
            for (int i = N - 1; i >= 0; i--) if (old_pend[i] && old_en[i]) low = i;
            if (low >= 0) begin
                presenting = 1;
                m_id = low;
            end
        end
        if (bus.en_we) m_en = bus.en_wdata;
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        model_edge();
        #1;
        chk("ExtIRQ", 32'(bus.ExtIRQ), 32'(presenting));
        chk("irq_id", 32'(bus.irq_id), 32'(m_id));
        chk("pending", 32'(bus.pending), 32'(m_pend));
    endtask

    task automatic wait_present(input string tag);
        int k;
        k = 0;
        while (!presenting && k < 30) begin
            step();
            k++;
        end
        if (!presenting) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic ack_pulse();
        bus.ExtIAck = 1'b1;
        step();
        bus.ExtIAck = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b0;
        bus.irq_src = '0;
        bus.en_we = 1'b0;
        bus.en_wdata = '0;
        bus.ExtIAck = 1'b0;
        model_reset();
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_ExtIRQ", 32'(bus.ExtIRQ), 32'd0);
        chk("rst_irq_id", 32'(bus.irq_id), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        reset = 1'b1;

        // Single source, one ack pulse
        bus.irq_src = 8'h08;
        repeat (SD + 1) step();
        chk("a_pend", 32'(bus.pending), 32'h08);
        chk("a_irq_lo", 32'(bus.ExtIRQ), 32'd0);
        step();
        chk("a_irq", 32'(bus.ExtIRQ), 32'd1);
        chk("a_id", 32'(bus.irq_id), 32'd3);
        bus.ExtIAck = 1'b1;
        step();
        chk("a_clr", 32'(bus.pending), 32'h00);
        chk("a_drop", 32'(bus.ExtIRQ), 32'd0);
        bus.ExtIAck = 1'b0;
        bus.irq_src = '0;
        repeat (SD + 3) step();

        // Two simultaneous sources served in index order
        bus.irq_src = 8'h24;
        wait_present("b0");
        chk("b_first", 32'(bus.irq_id), 32'd2);
        ack_pulse();
        wait_present("b1");
        chk("b_second", 32'(bus.irq_id), 32'd5);
        ack_pulse();
        bus.irq_src = '0;
        repeat (SD + 3) step();
        chk("b_end", 32'(bus.pending), 32'h00);

        // Masked source pends but is not presented until enabled
        bus.en_we = 1'b1;
        bus.en_wdata = 8'hFE;
        step();
        bus.en_we = 1'b0;
        bus.irq_src = 8'h01;
        repeat (SD + 3) step();
        chk("c_pend", 32'(bus.pending), 32'h01);
        chk("c_masked", 32'(bus.ExtIRQ), 32'd0);
        bus.en_we = 1'b1;
        bus.en_wdata = 8'hFF;
        step();
        bus.en_we = 1'b0;
        chk("c_still_lo", 32'(bus.ExtIRQ), 32'd0);
        step();
        chk("c_irq", 32'(bus.ExtIRQ), 32'd1);
        chk("c_id", 32'(bus.irq_id), 32'd0);
        ack_pulse();
        bus.irq_src = '0;
        repeat (SD + 3) step();

        // Re-rise of the acknowledged source in the ack cycle keeps it pending
        bus.irq_src = 8'h10;
        wait_present("d0");
        chk("d_id", 32'(bus.irq_id), 32'd4);
        bus.irq_src = '0;
        repeat (SD + 1) step();
        bus.irq_src = 8'h10;
        bus.ExtIAck = 1'b1;
        step();
        bus.ExtIAck = 1'b0;
        repeat (SD) step();
        chk("d_keep", 32'(bus.pending[4]), 32'd1);
        wait_present("d1");
        chk("d_again", 32'(bus.irq_id), 32'd4);
        ack_pulse();

        // Async reset while requesting; enable change must not retract first
        bus.irq_src = 8'h12;
        wait_present("e0");
        bus.en_we = 1'b1;
        bus.en_wdata = 8'h00;
        step();
        bus.en_we = 1'b0;
        chk("e_hold", 32'(bus.ExtIRQ), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("e_rst_irq", 32'(bus.ExtIRQ), 32'd0);
        chk("e_rst_pend", 32'(bus.pending), 32'd0);
        chk("e_rst_id", 32'(bus.irq_id), 32'd0);
        reset = 1'b1;
        repeat (SD + 1) step();
        chk("e_rearm", 32'(bus.pending), 32'h12);
        step();
        chk("e_en_reset", 32'(bus.ExtIRQ), 32'd1);
        chk("e_id", 32'(bus.irq_id), 32'd1);
        ack_pulse();
        ack_pulse();

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) bus.irq_src[$urandom_range(0, N - 1)] ^= 1'b1;
            if (presenting) bus.ExtIAck = ($urandom_range(0, 2) == 0);
            else if (waiting_release) bus.ExtIAck = $urandom_range(0, 1) == 1;
            else bus.ExtIAck = ($urandom_range(0, 7) == 0);
            bus.en_we = ($urandom_range(0, 15) == 0);
            bus.en_wdata = N'($urandom);
            if ($urandom_range(0, 3) != 0) bus.en_wdata |= N'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ext_irq_ctrl.md
EXT_IRQ_CTRL -- requirements
Module: ext_irq_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 8, number of external interrupt sources (2..32).
REQ-002 SHALL have parameter IDW, default $clog2(NSRC), width of the interrupt id.
REQ-003 SHALL have parameter EN_RESET, default all ones (NSRC bits), enable register reset value.
REQ-004 SHALL have port CLOCK_50  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port irq_src  input  NSRC  per-source interrupt request levels; rising edge requests.
REQ-007 SHALL have port en_we  input  1  enable register write strobe.
REQ-008 SHALL have port en_wdata  input  NSRC  enable register write data (1 = source enabled).
REQ-009 SHALL have port ExtIAck  input  1  processor acknowledge, high when exception entry is taken.
REQ-010 SHALL have port ExtIRQ  output  1  registered interrupt request to processor_arm.
REQ-011 SHALL have port irq_id  output  IDW  registered id of the source being presented.
REQ-012 SHALL have port pending  output  NSRC  registered pending bits.

Function
REQ-013 SHALL hold irq_src sampled history (irq_prev) and set pending[i] at an edge where irq_src[i]=1 and irq_prev[i]=0; levels alone never set pending.
REQ-014 SHALL set pending regardless of enable; enable gates only presentation.
REQ-015 SHALL implement FSM IDLE, ASSERT, ACKED.
REQ-016 IDLE: when (pending & en) != 0 at an edge, SHALL latch irq_id = lowest set index of (pending & en) and move to ASSERT.
REQ-017 ExtIRQ SHALL be 1 exactly while in ASSERT; first high one cycle after pending sets (latency 1 edge from pending, 2 edges from source rise).
REQ-018 ASSERT: SHALL hold ExtIRQ and irq_id stable until ExtIAck=1 sampled; en changes or lower-index arrivals SHALL NOT retract or change the request.
REQ-019 ASSERT with ExtIAck=1: SHALL clear pending[irq_id] and move to ACKED (ExtIRQ low next cycle).
REQ-020 ACKED: SHALL stay while ExtIAck=1 and return to IDLE on ExtIAck=0; no new request presented before IDLE.
REQ-021 ExtIAck in IDLE or ACKED SHALL be ignored for pending clearing.
REQ-022 Simultaneous new edge on source irq_id and clear in the same cycle: set SHALL win (pending stays 1).
REQ-023 en_we=1 SHALL load en from en_wdata at the edge; new value affects IDLE selection from the next edge.
REQ-024 Edges on several sources in the same cycle SHALL all set pending and be served one at a time in index order.

Reset
REQ-025 reset=0 SHALL immediately force: state IDLE, ExtIRQ=0, irq_id=0, pending=0, irq_prev=0, en=EN_RESET, synchronizer flops 0.
REQ-026 Reset mid-operation (ASSERT/ACKED) SHALL discard the in-flight request; a source held high across reset release SHALL register one edge at the first edge after release.

Configuration
REQ-027 Macro EXT_IRQ_SYNC_EN defined: irq_src SHALL pass through a 2-flop synchronizer per bit before edge detection; source-to-ExtIRQ latency becomes 4 edges.
REQ-028 Macro EXT_IRQ_SYNC_EN undefined: irq_src SHALL feed edge detection directly (sources synchronous to CLOCK_50); latency 2 edges.

Verification
REQ-029 Reset, then irq_src[3] 0->1 held -> pending=8'h08 after edge 1, ExtIRQ=1, irq_id=3 after edge 2; ExtIAck pulse 1 cycle -> pending=0, ExtIRQ=0 next cycle, FSM IDLE after ack low.
REQ-030 irq_src[5] and irq_src[2] rise same cycle -> irq_id=2 first; after ack/release, irq_id=5 presented; pending=8'h00 at end.
REQ-031 en=8'hFE, irq_src[0] rises -> pending=8'h01, ExtIRQ stays 0; write en=8'hFF -> ExtIRQ=1, irq_id=0 one cycle later.
REQ-032 In ASSERT with irq_id=4, irq_src[4] re-rises in the ExtIAck cycle -> pending[4] remains 1; source 4 presented again after ACKED->IDLE.
REQ-033 reset driven 0 while ExtIRQ=1 -> ExtIRQ, pending, irq_id 0 within the same cycle without a clock edge; en=8'hFF.
REQ-034 With EXT_IRQ_SYNC_EN, irq_src[1] rise -> ExtIRQ=1 exactly 4 edges later, irq_id=1.
